id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding network sitting directly upstream of the ALU.

---
 rtl/id_ex_operand_stage_if.sv | 60 ++++++
 rtl/id_ex_operand_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bus bundle between the decode stage / forwarding sources and the
// ID/EX operand stage, plus the ALU-facing outputs of that stage.
interface id_ex_operand_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int OP_W   = 3
);
   // decode slot
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm;
   logic [REG_AW-1:0] id_rd;
   logic [OP_W-1:0]   id_aluop;
   logic              id_alusrc;
   logic              id_regwrite;
   logic              id_memread;
   logic              id_memwrite;
   logic              flush;
   // forwarding sources
   logic              exmem_regwrite;
   logic [REG_AW-1:0] exmem_rd;
   logic [DATA_W-1:0] exmem_result;
   logic              memwb_regwrite;
   logic [REG_AW-1:0] memwb_rd;
   logic [DATA_W-1:0] memwb_data;
   // EX-side outputs
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   logic [OP_W-1:0]   aluop;
   logic [DATA_W-1:0] ex_store_data;
   logic              ex_valid;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_regwrite;
   logic              ex_memread;
   logic              ex_memwrite;
   logic              stall;

   // decode / forwarding driver side
   modport master (
      output id_valid, id_rs, id_rt, id_rs_data, id_rt_data, id_imm, id_rd,
             id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite, flush,
             exmem_regwrite, exmem_rd, exmem_result,
             memwb_regwrite, memwb_rd, memwb_data,
      input  read_data1, read_data2, aluop, ex_store_data, ex_valid, ex_rd,
             ex_regwrite, ex_memread, ex_memwrite, stall
   );

   // operand stage side
   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_data, id_rt_data, id_imm, id_rd,
             id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite, flush,
             exmem_regwrite, exmem_rd, exmem_result,
             memwb_regwrite, memwb_rd, memwb_data,
      output read_data1, read_data2, aluop, ex_store_data, ex_valid, ex_rd,
             ex_regwrite, ex_memread, ex_memwrite, stall
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection. Feeds the ALU operands and opcode directly.
module id_ex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int OP_W   = 3,
   parameter bit FWD_EN = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   id_ex_operand_stage_if.slave bus
);

   // EX-stage registers (a cleared register set is a bubble)
   logic              vld_p1;
   logic [REG_AW-1:0] rs_p1;
   logic [REG_AW-1:0] rt_p1;
   logic [DATA_W-1:0] rs_data_p1;
   logic [DATA_W-1:0] rt_data_p1;
   logic [DATA_W-1:0] imm_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [OP_W-1:0]   aluop_p1;
   logic              alusrc_p1;
   logic              regwrite_p1;
   logic              memread_p1;
   logic              memwrite_p1;

   logic              stall;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;

   // Newest producer wins: EX/MEM before MEM/WB. Register 0 is hard-wired
   // to zero, so it is never a forwarding target.
   function automatic logic [DATA_W-1:0] fwd_operand(
      input logic [REG_AW-1:0] src,
      input logic [DATA_W-1:0] reg_data,
      input logic              em_we,
      input logic [REG_AW-1:0] em_rd,
      input logic [DATA_W-1:0] em_data,
      input logic              mw_we,
      input logic [REG_AW-1:0] mw_rd,
      input logic [DATA_W-1:0] mw_data
   );
      if (em_we && (em_rd != '0) && (em_rd == src))
         return em_data;
      else if (mw_we && (mw_rd != '0) && (mw_rd == src))
         return mw_data;
      else
         return reg_data;
   endfunction

   // Load-use hazard: the load in EX cannot supply its data until MEM/WB,
   // so a dependent instruction in decode must wait one cycle. A flush
   // kills the dependent instruction anyway, so no stall is needed.
   always_comb begin
      stall = vld_p1 && memread_p1 && (rd_p1 != '0) && bus.id_valid &&
              ((bus.id_rs == rd_p1) || (bus.id_rt == rd_p1)) && !bus.flush;
   end

   // ---- ID -> EX boundary ----
   // Flush and stall both insert a bubble; otherwise capture the decode slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         rs_p1       <= '0;
         rt_p1       <= '0;
         rs_data_p1  <= '0;
         rt_data_p1  <= '0;
         imm_p1      <= '0;
         rd_p1       <= '0;
         aluop_p1    <= '0;
         alusrc_p1   <= 1'b0;
         regwrite_p1 <= 1'b0;
         memread_p1  <= 1'b0;
         memwrite_p1 <= 1'b0;
      end else if (bus.flush || stall) begin
         vld_p1      <= 1'b0;
         rs_p1       <= '0;
         rt_p1       <= '0;
         rs_data_p1  <= '0;
         rt_data_p1  <= '0;
         imm_p1      <= '0;
         rd_p1       <= '0;
         aluop_p1    <= '0;
         alusrc_p1   <= 1'b0;
         regwrite_p1 <= 1'b0;
         memread_p1  <= 1'b0;
         memwrite_p1 <= 1'b0;
      end else begin
         vld_p1      <= bus.id_valid;
         rs_p1       <= bus.id_rs;
         rt_p1       <= bus.id_rt;
         rs_data_p1  <= bus.id_rs_data;
         rt_data_p1  <= bus.id_rt_data;
         imm_p1      <= bus.id_imm;
         rd_p1       <= bus.id_rd;
         aluop_p1    <= bus.id_aluop;
         alusrc_p1   <= bus.id_alusrc;
         regwrite_p1 <= bus.id_regwrite;
         memread_p1  <= bus.id_memread;
         memwrite_p1 <= bus.id_memwrite;
      end
   end

   // Operand selection from the registered sources, bypassed when
   // forwarding is disabled.
   always_comb begin
      fwd_a = rs_data_p1;
      fwd_b = rt_data_p1;
      if (FWD_EN) begin
         fwd_a = fwd_operand(rs_p1, rs_data_p1,
                             bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                             bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data);
         fwd_b = fwd_operand(rt_p1, rt_data_p1,
                             bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                             bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data);
      end
   end

   assign bus.read_data1    = fwd_a;
   assign bus.read_data2    = alusrc_p1 ? imm_p1 : fwd_b;
   assign bus.ex_store_data = fwd_b;
   assign bus.aluop         = aluop_p1;
   assign bus.ex_valid      = vld_p1;
   assign bus.ex_rd         = rd_p1;
   assign bus.ex_regwrite   = regwrite_p1;
   assign bus.ex_memread    = memread_p1;
   assign bus.ex_memwrite   = memwrite_p1;
   assign bus.stall         = stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, capture, forwarding
// priority, register-0 exclusion, load-use stall, flush, immediate/store path.
module tb_id_ex_operand_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int OP_W   = 3;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   id_ex_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W)) bus ();

   id_ex_operand_stage #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W), .FWD_EN(1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // idle decode slot and quiet forwarding sources
   task automatic clear_inputs();
      bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0;
      bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
      bus.id_rd = '0; bus.id_aluop = '0; bus.id_alusrc = 0;
      bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
      bus.flush = 0;
      bus.exmem_regwrite = 0; bus.exmem_rd = '0; bus.exmem_result = '0;
      bus.memwb_regwrite = 0; bus.memwb_rd = '0; bus.memwb_data = '0;
   endtask

   // place a load to r4 in the decode slot (captured on the next step)
   task automatic drive_load_r4();
      clear_inputs();
      bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_rt = 5'd2;
      bus.id_rd = 5'd4; bus.id_regwrite = 1; bus.id_memread = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      for (int i = 0; i < 4; i++) begin
         bus.id_valid = 1'($urandom); bus.id_rs = REG_AW'($urandom);
         bus.id_rt = REG_AW'($urandom); bus.id_rs_data = $urandom;
         bus.id_rt_data = $urandom; bus.id_imm = $urandom;
         bus.id_rd = REG_AW'($urandom); bus.id_aluop = OP_W'($urandom);
         bus.id_alusrc = 1'($urandom); bus.id_regwrite = 1'($urandom);
         bus.id_memread = 1'($urandom); bus.id_memwrite = 1'($urandom);
         bus.flush = 1'($urandom);
         bus.exmem_regwrite = 1'($urandom); bus.exmem_rd = REG_AW'($urandom);
         bus.exmem_result = $urandom;
         bus.memwb_regwrite = 1'($urandom); bus.memwb_rd = REG_AW'($urandom);
         bus.memwb_data = $urandom;
         step();
      end
      checks++; if (bus.read_data1 !== 32'd0) begin errors++; $display("FAIL reset_rd1: got %h expected %h", bus.read_data1, 32'd0); end
      checks++; if (bus.read_data2 !== 32'd0) begin errors++; $display("FAIL reset_rd2: got %h expected %h", bus.read_data2, 32'd0); end
      checks++; if (bus.ex_store_data !== 32'd0) begin errors++; $display("FAIL reset_store: got %h expected %h", bus.ex_store_data, 32'd0); end
      checks++; if (bus.aluop !== 3'd0) begin errors++; $display("FAIL reset_aluop: got %h expected %h", bus.aluop, 3'd0); end
      checks++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", {bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}, 4'b0000); end
      checks++; if (bus.ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h expected %h", bus.ex_rd, 5'd0); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", bus.stall, 1'b0); end
   endtask

   task automatic test_capture();
      clear_inputs();
      rst_n = 1;
      bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_rt = 5'd2;
      bus.id_rs_data = 32'd5; bus.id_rt_data = 32'd7;
      bus.id_aluop = 3'b010; bus.id_rd = 5'd6; bus.id_regwrite = 1;
      #1;
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL capture_latency: got %b expected %b", bus.ex_valid, 1'b0); end
      step();
      checks++; if (bus.read_data1 !== 32'd5) begin errors++; $display("FAIL capture_rd1: got %h expected %h", bus.read_data1, 32'd5); end
      checks++; if (bus.read_data2 !== 32'd7) begin errors++; $display("FAIL capture_rd2: got %h expected %h", bus.read_data2, 32'd7); end
      checks++; if (bus.aluop !== 3'b010) begin errors++; $display("FAIL capture_aluop: got %h expected %h", bus.aluop, 3'b010); end
      checks++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_rd} !== {1'b1, 1'b1, 5'd6}) begin errors++; $display("FAIL capture_ctrl: got %b expected %b", {bus.ex_valid, bus.ex_regwrite, bus.ex_rd}, {1'b1, 1'b1, 5'd6}); end
   endtask

   task automatic test_forward_priority();
      clear_inputs();
      bus.id_valid = 1; bus.id_rs = 5'd3; bus.id_rt = 5'd8;
      bus.id_rs_data = 32'h1; bus.id_rt_data = 32'h2;
      step();
      clear_inputs();
      bus.exmem_regwrite = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h10;
      bus.memwb_regwrite = 1; bus.memwb_rd = 5'd3; bus.memwb_data = 32'h20;
      #1;
      checks++; if (bus.read_data1 !== 32'h10) begin errors++; $display("FAIL fwd_exmem_wins: got %h expected %h", bus.read_data1, 32'h10); end
      checks++; if (bus.read_data2 !== 32'h2) begin errors++; $display("FAIL fwd_b_nomatch: got %h expected %h", bus.read_data2, 32'h2); end
      bus.exmem_regwrite = 0;
      #1;
      checks++; if (bus.read_data1 !== 32'h20) begin errors++; $display("FAIL fwd_memwb: got %h expected %h", bus.read_data1, 32'h20); end
      bus.memwb_regwrite = 0;
      #1;
      checks++; if (bus.read_data1 !== 32'h1) begin errors++; $display("FAIL fwd_none: got %h expected %h", bus.read_data1, 32'h1); end
   endtask

   task automatic test_reg_zero();
      clear_inputs();
      bus.id_valid = 1; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
      step();
      clear_inputs();
      bus.exmem_regwrite = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h55;
      bus.memwb_regwrite = 1; bus.memwb_rd = 5'd0; bus.memwb_data = 32'h66;
      #1;
      checks++; if (bus.read_data1 !== 32'd0) begin errors++; $display("FAIL r0_fwd_a: got %h expected %h", bus.read_data1, 32'd0); end
      checks++; if (bus.ex_store_data !== 32'd0) begin errors++; $display("FAIL r0_fwd_b: got %h expected %h", bus.ex_store_data, 32'd0); end
   endtask

   task automatic test_load_use();
      drive_load_r4();
      step();
      clear_inputs();
      bus.id_valid = 1; bus.id_rs = 5'd4; bus.id_rt = 5'd5;
      bus.id_rs_data = 32'hDEAD; bus.id_rt_data = 32'h3;
      bus.id_aluop = 3'b001; bus.id_rd = 5'd7; bus.id_regwrite = 1;
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %b expected %b", bus.stall, 1'b1); end
      step();
      bus.exmem_regwrite = 1; bus.exmem_rd = 5'd4; bus.exmem_result = 32'h0;
      #1;
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected %b", bus.ex_valid, 1'b0); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle: got %b expected %b", bus.stall, 1'b0); end
      step();
      bus.exmem_regwrite = 0; bus.exmem_rd = 5'd0;
      bus.memwb_regwrite = 1; bus.memwb_rd = 5'd4; bus.memwb_data = 32'h44;
      #1;
      checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_captured: got %b expected %b", bus.ex_valid, 1'b1); end
      checks++; if (bus.read_data1 !== 32'h44) begin errors++; $display("FAIL lu_fwd_memwb: got %h expected %h", bus.read_data1, 32'h44); end
      checks++; if (bus.read_data2 !== 32'h3) begin errors++; $display("FAIL lu_rd2: got %h expected %h", bus.read_data2, 32'h3); end
      checks++; if (bus.ex_rd !== 5'd7) begin errors++; $display("FAIL lu_ex_rd: got %h expected %h", bus.ex_rd, 5'd7); end
   endtask

   task automatic test_flush();
      drive_load_r4();
      step();
      clear_inputs();
      bus.id_valid = 1; bus.id_rs = 5'd4; bus.id_rd = 5'd9; bus.id_regwrite = 1;
      bus.flush = 1;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_no_stall: got %b expected %b", bus.stall, 1'b0); end
      step();
      checks++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memread} !== 3'b000) begin errors++; $display("FAIL flush_bubble: got %b expected %b", {bus.ex_valid, bus.ex_regwrite, bus.ex_memread}, 3'b000); end
      checks++; if (bus.ex_rd !== 5'd0) begin errors++; $display("FAIL flush_rd: got %h expected %h", bus.ex_rd, 5'd0); end
   endtask

   task automatic test_alusrc_store();
      clear_inputs();
      bus.id_valid = 1; bus.id_rs = 5'd0; bus.id_rt = 5'd6;
      bus.id_rt_data = 32'h1; bus.id_imm = 32'hFFFFFFFC;
      bus.id_alusrc = 1; bus.id_memwrite = 1;
      step();
      clear_inputs();
      bus.exmem_regwrite = 1; bus.exmem_rd = 5'd6; bus.exmem_result = 32'd9;
      #1;
      checks++; if (bus.read_data2 !== 32'hFFFFFFFC) begin errors++; $display("FAIL imm_rd2: got %h expected %h", bus.read_data2, 32'hFFFFFFFC); end
      checks++; if (bus.ex_store_data !== 32'd9) begin errors++; $display("FAIL store_fwd: got %h expected %h", bus.ex_store_data, 32'd9); end
      checks++; if (bus.ex_memwrite !== 1'b1) begin errors++; $display("FAIL store_memwrite: got %b expected %b", bus.ex_memwrite, 1'b1); end
   endtask

   task automatic test_reset_mid_stall();
      drive_load_r4();
      step();
      clear_inputs();
      bus.id_valid = 1; bus.id_rt = 5'd4;
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mid_stall_on: got %b expected %b", bus.stall, 1'b1); end
      #1;
      rst_n = 0;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %b expected %b", bus.stall, 1'b0); end
      checks++; if (bus.ex_memread !== 1'b0) begin errors++; $display("FAIL mid_reset_memread: got %b expected %b", bus.ex_memread, 1'b0); end
      step();
      rst_n = 1;
      clear_inputs();
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      clear_inputs();
      test_reset();
      test_capture();
      test_forward_priority();
      test_reg_zero();
      test_load_use();
      test_flush();
      test_alusrc_store();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
